// File: rtl/vcm_i2c_tx.sv
// vcm_i2c_tx: sends the 16-bit VCM focus word to the voice-coil driver as a
// single I2C write (START, address+W, data[15:8], data[7:0], STOP) on an
// open-drain SCL/SDA pair, checking the slave ACK after every byte.
module vcm_i2c_tx #(
    parameter int          CLK_DIV  = 16,     // CLK cycles per quarter SCL period, >= 4
    parameter logic [6:0]  DEV_ADDR = 7'h0C   // 7-bit I2C address of the VCM driver
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [15:0] VCM_DATA,
    input  logic        GO,
    input  logic        AUTO_EN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ACK_ERR,
    output logic [15:0] LAST_DATA,
    output logic        I2C_SCL,
    output logic        I2C_SDA_OE,
    input  logic        I2C_SDA_IN
);

    localparam int             CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BITS,
        ACK,
        STOP
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;        // cycle within the current quarter
    logic [1:0]     q;          // quarter within the current slot
    logic [2:0]     bit_cnt;    // bit within the current byte
    logic [1:0]     byte_cnt;   // 0 = address, 1 = data[15:8], 2 = data[7:0]
    logic [23:0]    shift;      // remaining bits, current bit in [23]
    logic [1:0]     sda_sync;
    logic           sda_s;
    logic           req;
    logic           quarter_end;

    assign sda_s       = sda_sync[1];
    assign req         = GO | (AUTO_EN & (VCM_DATA != LAST_DATA));
    assign quarter_end = (cnt == CNT_MAX);

    // Two-flop synchronizer for the asynchronous SDA pin level.
    always_ff @(posedge CLK) begin
        // NOTE: the synchronizer resets to the idle bus level (high) so a
        // reset can never look like an ACK on the first sample afterwards.
        if (!RESET_n) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], I2C_SDA_IN};
        end
    end

    // Transaction FSM: slot/quarter timing, bit shifting, ACK check and
    // registered bus/status outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state      <= IDLE;
            cnt        <= '0;
            q          <= 2'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 2'd0;
            shift      <= 24'h0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ACK_ERR    <= 1'b0;
            LAST_DATA  <= 16'h0000;
            I2C_SCL    <= 1'b1;
            I2C_SDA_OE <= 1'b0;
        end else begin
            // NOTE: every assignment here is non-blocking, so each test below
            // sees register values from before this edge, and later
            // assignments in the block simply override the defaults.
            DONE <= 1'b0;

            // The quarter counter only runs while a transaction is active.
            if (state != IDLE) begin
                if (quarter_end) begin
                    cnt <= '0;
                    q   <= q + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        shift      <= {DEV_ADDR, 1'b0, VCM_DATA};
                        LAST_DATA  <= VCM_DATA;
                        ACK_ERR    <= 1'b0;
                        BUSY       <= 1'b1;
                        byte_cnt   <= 2'd0;
                        bit_cnt    <= 3'd0;
                        cnt        <= '0;
                        q          <= 2'd0;
                        I2C_SCL    <= 1'b1;
                        I2C_SDA_OE <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (quarter_end) begin
                        // SDA falls halfway through the slot while SCL stays high.
                        if (q == 2'd1) begin
                            I2C_SDA_OE <= 1'b1;
                        end
                        if (q == 2'd3) begin
                            I2C_SCL    <= 1'b0;
                            I2C_SDA_OE <= ~shift[23];
                            bit_cnt    <= 3'd0;
                            state      <= BITS;
                        end
                    end
                end

                BITS: begin
                    if (quarter_end) begin
                        if (q == 2'd1) begin
                            I2C_SCL <= 1'b1;
                        end
                        if (q == 2'd3) begin
                            I2C_SCL <= 1'b0;
                            shift   <= {shift[22:0], 1'b0};
                            if (bit_cnt == 3'd7) begin
                                // Release SDA so the slave can drive the ACK bit.
                                I2C_SDA_OE <= 1'b0;
                                state      <= ACK;
                            end else begin
                                I2C_SDA_OE <= ~shift[22];
                                bit_cnt    <= bit_cnt + 3'd1;
                            end
                        end
                    end
                end

                ACK: begin
                    if (quarter_end) begin
                        if (q == 2'd1) begin
                            I2C_SCL <= 1'b1;
                        end
                        if (q == 2'd3) begin
                            I2C_SCL <= 1'b0;
                            if (sda_s) begin
                                // NACK: abandon the remaining bytes and stop.
                                ACK_ERR    <= 1'b1;
                                I2C_SDA_OE <= 1'b1;
                                state      <= STOP;
                            end else if (byte_cnt == 2'd2) begin
                                I2C_SDA_OE <= 1'b1;
                                state      <= STOP;
                            end else begin
                                byte_cnt   <= byte_cnt + 2'd1;
                                bit_cnt    <= 3'd0;
                                I2C_SDA_OE <= ~shift[23];
                                state      <= BITS;
                            end
                        end
                    end
                end

                STOP: begin
                    if (quarter_end) begin
                        if (q == 2'd1) begin
                            I2C_SCL <= 1'b1;
                        end
                        // SDA rises one quarter after SCL to form the STOP edge.
                        if (q == 2'd2) begin
                            I2C_SDA_OE <= 1'b0;
                        end
                        if (q == 2'd3) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vcm_i2c_tx.sv
// Directed testbench for vcm_i2c_tx: a bus monitor with an ACK/NACK slave
// model on a CLK_DIV=4 instance, plus a CLK_DIV=7 instance for SCL timing.
module tb_vcm_i2c_tx;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET_n;
    logic [15:0] VCM_DATA;
    logic        GO;
    logic        AUTO_EN;
    logic        BUSY, DONE, ACK_ERR;
    logic [15:0] LAST_DATA;
    logic        I2C_SCL, I2C_SDA_OE;
    logic        slave_pull;
    wire         sda_line = !(I2C_SDA_OE || slave_pull);
    wire         I2C_SDA_IN = sda_line;

    logic        go7;
    logic        auto7;
    logic        busy7, done7, ack_err7;
    logic [15:0] last_data7;
    logic        scl7, oe7;
    logic        pull7;
    wire         sda7 = !(oe7 || pull7);

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    vcm_i2c_tx #(.CLK_DIV(4), .DEV_ADDR(7'h0C)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .VCM_DATA(VCM_DATA), .GO(GO), .AUTO_EN(AUTO_EN),
        .BUSY(BUSY), .DONE(DONE), .ACK_ERR(ACK_ERR), .LAST_DATA(LAST_DATA),
        .I2C_SCL(I2C_SCL), .I2C_SDA_OE(I2C_SDA_OE), .I2C_SDA_IN(I2C_SDA_IN)
    );

    vcm_i2c_tx #(.CLK_DIV(7), .DEV_ADDR(7'h0C)) dut7 (
        .CLK(CLK), .RESET_n(RESET_n), .VCM_DATA(VCM_DATA), .GO(go7), .AUTO_EN(auto7),
        .BUSY(busy7), .DONE(done7), .ACK_ERR(ack_err7), .LAST_DATA(last_data7),
        .I2C_SCL(scl7), .I2C_SDA_OE(oe7), .I2C_SDA_IN(sda7)
    );

    always @(posedge CLK) cyc <= cyc + 1;

    // Bus monitor + slave model for the CLK_DIV=4 instance (sampled on negedge)
    logic       p_scl = 1'b1, p_sda = 1'b1, seen_rise = 1'b0;
    logic       bits [0:26];
    logic [2:0] ack_mask;
    int starts, stops, nbits, pulses, ack_oe_bad, done_cnt;

    always @(negedge CLK) begin
        if (p_scl && I2C_SCL && p_sda && !sda_line) begin
            starts++;
            nbits = 0;
            seen_rise = 1'b0;
        end
        if (p_scl && I2C_SCL && !p_sda && sda_line) stops++;
        if (!p_scl && I2C_SCL) begin
            seen_rise = 1'b1;
            if (nbits < 27) begin
                bits[nbits] = sda_line;
                if ((nbits % 9) == 8 && I2C_SDA_OE) ack_oe_bad++;
            end
            nbits++;
        end
        if (p_scl && !I2C_SCL) begin
            if (seen_rise) pulses++;
            slave_pull = ((nbits % 9) == 8) && (nbits < 27) && ack_mask[nbits / 9];
        end
        if (DONE === 1'b1) done_cnt++;
        p_scl = I2C_SCL;
        p_sda = sda_line;
    end

    // Always-ACK slave and SCL phase timer for the CLK_DIV=7 instance
    logic p_scl7 = 1'b1, p_sda7 = 1'b1, have7 = 1'b0;
    int f7, runs7, bad7, edge7;

    always @(negedge CLK) begin
        if (p_scl7 && scl7 && p_sda7 && !sda7) begin
            f7 = 0;
            have7 = 1'b0;
        end
        if (scl7 !== p_scl7 && busy7 === 1'b1) begin
            if (have7) begin
                runs7++;
                if (cyc - edge7 != 14) bad7++;
            end
            have7 = 1'b1;
            edge7 = cyc;
        end
        if (p_scl7 && !scl7) begin
            f7++;
            pull7 = ((f7 % 9) == 0) && (f7 <= 27);
        end
        p_scl7 = scl7;
        p_sda7 = sda7;
    end

    task automatic clear_mon();
        @(posedge CLK);
        #1;
        starts = 0; stops = 0; nbits = 0; pulses = 0; ack_oe_bad = 0; done_cnt = 0;
        seen_rise = 1'b0;
        slave_pull = 1'b0;
        for (int i = 0; i < 27; i++) bits[i] = 1'b0;
        @(negedge CLK);
    endtask

    function automatic logic [7:0] rx_byte(input int k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits[9 * k + i]};
        return b;
    endfunction

    // Drive a one-cycle GO at a negedge; t0 is the acceptance cycle.
    task automatic send_go(input logic [15:0] d, output int t0);
        @(negedge CLK);
        VCM_DATA = d;
        GO = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        GO = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (DONE === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({BUSY, DONE, ACK_ERR, I2C_SCL, I2C_SDA_OE} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00010", {BUSY, DONE, ACK_ERR, I2C_SCL, I2C_SDA_OE});
        end
        checks++;
        if (LAST_DATA !== 16'h0000) begin
            errors++;
            $display("FAIL reset_last_data: got %h expected 0000", LAST_DATA);
        end
        RESET_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_full();
        int t0, lat;
        clear_mon();
        ack_mask = 3'b111;
        send_go(16'h1A3F, t0);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL full_busy_t1: got %b expected 1", BUSY);
        end
        wait_done(t0, 700, lat);
        checks++;
        if (lat != 465) begin
            errors++;
            $display("FAIL full_done_latency: got %0d expected 465", lat);
        end
        checks++;
        if (ACK_ERR !== 1'b0 || LAST_DATA !== 16'h1A3F) begin
            errors++;
            $display("FAIL full_status: got ack_err=%b last=%h expected 0 1a3f", ACK_ERR, LAST_DATA);
        end
        checks++;
        if ({rx_byte(0), rx_byte(1), rx_byte(2)} !== 24'h181A3F) begin
            errors++;
            $display("FAIL full_bytes: got %h %h %h expected 18 1a 3f", rx_byte(0), rx_byte(1), rx_byte(2));
        end
        checks++;
        if (ack_oe_bad != 0 || bits[8] !== 1'b0 || bits[17] !== 1'b0 || bits[26] !== 1'b0) begin
            errors++;
            $display("FAIL full_ack_bits: got oe_bad=%0d acks=%b%b%b expected 0 000", ack_oe_bad, bits[8], bits[17], bits[26]);
        end
        checks++;
        if (starts != 1 || stops != 1 || pulses != 27) begin
            errors++;
            $display("FAIL full_framing: got starts=%0d stops=%0d pulses=%0d expected 1 1 27", starts, stops, pulses);
        end
    endtask

    task automatic test_nack();
        int t0, t1, lat;
        clear_mon();
        ack_mask = 3'b110;
        send_go(16'h1A3F, t0);
        wait_done(t0, 700, lat);
        checks++;
        if (lat != 177) begin
            errors++;
            $display("FAIL nack_done_latency: got %0d expected 177", lat);
        end
        checks++;
        if (ACK_ERR !== 1'b1) begin
            errors++;
            $display("FAIL nack_ack_err: got %b expected 1", ACK_ERR);
        end
        checks++;
        if (pulses != 9 || stops != 1 || rx_byte(0) !== 8'h18) begin
            errors++;
            $display("FAIL nack_framing: got pulses=%0d stops=%0d byte0=%h expected 9 1 18", pulses, stops, rx_byte(0));
        end
        // GO in the DONE cycle is accepted and clears ACK_ERR.
        ack_mask = 3'b111;
        VCM_DATA = 16'h55AA;
        GO = 1'b1;
        t1 = cyc;
        @(negedge CLK);
        GO = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || ACK_ERR !== 1'b0) begin
            errors++;
            $display("FAIL nack_go_in_done: got busy=%b ack_err=%b expected 1 0", BUSY, ACK_ERR);
        end
        wait_done(t1, 700, lat);
        checks++;
        if (lat != 465 || ACK_ERR !== 1'b0) begin
            errors++;
            $display("FAIL nack_recover: got lat=%0d ack_err=%b expected 465 0", lat, ACK_ERR);
        end
    endtask

    task automatic test_go_during_busy();
        int t0, lat;
        clear_mon();
        ack_mask = 3'b111;
        send_go(16'h1A3F, t0);
        while (cyc < t0 + 100) @(negedge CLK);
        VCM_DATA = 16'h2222;
        GO = 1'b1;
        @(negedge CLK);
        GO = 1'b0;
        wait_done(t0, 700, lat);
        checks++;
        if (lat != 465) begin
            errors++;
            $display("FAIL busy_go_latency: got %0d expected 465", lat);
        end
        checks++;
        if ({rx_byte(0), rx_byte(1), rx_byte(2)} !== 24'h181A3F || LAST_DATA !== 16'h1A3F) begin
            errors++;
            $display("FAIL busy_go_data: got %h%h%h last=%h expected 181a3f 1a3f", rx_byte(0), rx_byte(1), rx_byte(2), LAST_DATA);
        end
        repeat (600) @(negedge CLK);
        checks++;
        if (done_cnt != 1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL busy_go_single: got dones=%0d busy=%b expected 1 0", done_cnt, BUSY);
        end
    endtask

    task automatic test_auto();
        int t0, lat;
        @(negedge CLK);
        RESET_n = 1'b0;
        @(negedge CLK);
        RESET_n = 1'b1;
        VCM_DATA = 16'h00F0;
        clear_mon();
        ack_mask = 3'b111;
        AUTO_EN = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL auto_start: got busy=%b expected 1", BUSY);
        end
        wait_done(t0, 700, lat);
        checks++;
        if (lat != 465 || LAST_DATA !== 16'h00F0 || {rx_byte(1), rx_byte(2)} !== 16'h00F0) begin
            errors++;
            $display("FAIL auto_first: got lat=%0d last=%h data=%h%h expected 465 00f0 00f0", lat, LAST_DATA, rx_byte(1), rx_byte(2));
        end
        repeat (300) @(negedge CLK);
        checks++;
        if (done_cnt != 1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL auto_hold: got dones=%0d busy=%b expected 1 0", done_cnt, BUSY);
        end
        // New word together with GO: exactly one more transaction.
        clear_mon();
        VCM_DATA = 16'h0100;
        GO = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        GO = 1'b0;
        wait_done(t0, 700, lat);
        repeat (600) @(negedge CLK);
        checks++;
        if (lat != 465 || done_cnt != 1) begin
            errors++;
            $display("FAIL auto_change: got lat=%0d dones=%0d expected 465 1", lat, done_cnt);
        end
        checks++;
        if ({rx_byte(0), rx_byte(1), rx_byte(2)} !== 24'h180100 || LAST_DATA !== 16'h0100) begin
            errors++;
            $display("FAIL auto_change_data: got %h%h%h last=%h expected 180100 0100", rx_byte(0), rx_byte(1), rx_byte(2), LAST_DATA);
        end
        AUTO_EN = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t0, lat;
        clear_mon();
        ack_mask = 3'b111;
        send_go(16'h1A3F, t0);
        while (cyc < t0 + 200) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_busy: got %b expected 1", BUSY);
        end
        RESET_n = 1'b0;
        @(negedge CLK);
        checks++;
        if ({BUSY, DONE, ACK_ERR, I2C_SCL, I2C_SDA_OE} !== 5'b00010 || LAST_DATA !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b last=%h expected 00010 0000", {BUSY, DONE, ACK_ERR, I2C_SCL, I2C_SDA_OE}, LAST_DATA);
        end
        RESET_n = 1'b1;
        clear_mon();
        send_go(16'h0C0C, t0);
        wait_done(t0, 700, lat);
        checks++;
        if (lat != 465 || ACK_ERR !== 1'b0 || {rx_byte(0), rx_byte(1), rx_byte(2)} !== 24'h180C0C) begin
            errors++;
            $display("FAIL midreset_recover: got lat=%0d ack_err=%b data=%h%h%h expected 465 0 180c0c", lat, ACK_ERR, rx_byte(0), rx_byte(1), rx_byte(2));
        end
    endtask

    task automatic test_div7();
        int t0, lat;
        @(negedge CLK);
        runs7 = 0; bad7 = 0;
        VCM_DATA = 16'h1A3F;
        go7 = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        go7 = 1'b0;
        lat = -1;
        for (int i = 0; i < 1200; i++) begin
            if (done7 === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (lat != 813) begin
            errors++;
            $display("FAIL div7_done_latency: got %0d expected 813", lat);
        end
        checks++;
        if (runs7 != 55 || bad7 != 0) begin
            errors++;
            $display("FAIL div7_scl_phases: got runs=%0d bad=%0d expected 55 0", runs7, bad7);
        end
        checks++;
        if (ack_err7 !== 1'b0 || last_data7 !== 16'h1A3F) begin
            errors++;
            $display("FAIL div7_status: got ack_err=%b last=%h expected 0 1a3f", ack_err7, last_data7);
        end
    endtask

    initial begin
        RESET_n = 1'b0;
        VCM_DATA = 16'h0000;
        GO = 1'b0;
        AUTO_EN = 1'b0;
        go7 = 1'b0;
        auto7 = 1'b0;
        slave_pull = 1'b0;
        pull7 = 1'b0;
        ack_mask = 3'b111;
        test_reset();
        test_full();
        test_nack();
        test_go_during_busy();
        test_auto();
        test_reset_mid();
        test_div7();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
